// File: rtl/serial_byte_adder.sv
// rtl/serial_byte_adder.sv - multi-byte adder that reuses one external 8-bit adder, one byte per cycle
module serial_byte_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    input  logic                  cin,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum_out,
    output logic                  cout,
    output logic                  ovf
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [7:0]    a_bytes   [NBYTES];
    logic [7:0]    b_bytes   [NBYTES];
    logic [7:0]    sum_bytes [NBYTES];
    logic          a_msb;
    logic          b_msb;

    assign a_msb = a_bytes[NBYTES-1][7];
    assign b_msb = b_bytes[NBYTES-1][7];

    // The external adder sits in the same cycle as the byte select, so these must stay combinational.
    always_comb begin
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_bytes[idx];
            add_b   = b_bytes[idx];
            add_cin = carry;
        end
    end

    for (genvar g = 0; g < NBYTES; g++) begin : g_sum
        assign sum_out[g*8 +: 8] = sum_bytes[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                a_bytes[i]   <= 8'd0;
                b_bytes[i]   <= 8'd0;
                sum_bytes[i] <= 8'd0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    // DONE accepts start like IDLE so back-to-back operations need no idle gap.
                    if (start) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            a_bytes[i] <= a_in[i*8 +: 8];
                            b_bytes[i] <= b_in[i*8 +: 8];
                        end
                        carry <= cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_bytes[idx] <= add_sum;
                    carry          <= add_cout;
                    idx            <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout  <= add_cout;
                        ovf   <= (a_msb == b_msb) && (add_sum[7] != a_msb);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_adder.sv
// tb/tb_serial_byte_adder.sv - randomized self-checking bench for serial_byte_adder with an 8-bit ripple adder
module tb_serial_byte_adder;

    localparam int NBYTES = 4;
    localparam int W = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          cin = 1'b0;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum_out;
    logic          cout;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    serial_byte_adder #(.NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width two's-complement addition.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // Issue one start and wait (bounded) for done; records latency, busy cycles and add_cin per RUN cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output int lat, output int busy_n, output logic [7:0] cin_tr);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        step();
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        cin_tr = 8'd0;
        while (!done && lat < 20) begin
            if (busy) begin
                if (busy_n < 8) cin_tr[busy_n] = add_cin;
                busy_n++;
            end
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        step();
        step();
        checks++;
        if ({busy, done, cout, ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/cout/ovf=%b expected 0000", {busy, done, cout, ovf});
        end
        checks++;
        if (sum_out !== '0) begin
            errors++;
            $display("FAIL reset_sum: got %h expected 0", sum_out);
        end
        checks++;
        if ({add_a, add_b, add_cin} !== 17'd0) begin
            errors++;
            $display("FAIL reset_adder_if: got %h expected 0", {add_a, add_b, add_cin});
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic         tc [3];
        logic [W-1:0] ts [3];
        logic         tco[3];
        logic         tov[3];
        logic [7:0]   cin_tr;
        int lat, busy_n;
        ta[0] = 32'hFFFFFFFF; tb[0] = 32'h00000001; tc[0] = 1'b0; ts[0] = 32'h00000000; tco[0] = 1'b1; tov[0] = 1'b0;
        ta[1] = 32'h7FFFFFFF; tb[1] = 32'h00000001; tc[1] = 1'b0; ts[1] = 32'h80000000; tco[1] = 1'b0; tov[1] = 1'b1;
        ta[2] = 32'h00000000; tb[2] = 32'h00000000; tc[2] = 1'b1; ts[2] = 32'h00000001; tco[2] = 1'b0; tov[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], tc[i], lat, busy_n, cin_tr);
            checks++;
            if (lat !== NBYTES || busy_n !== NBYTES) begin
                errors++;
                $display("FAIL directed%0d_latency: lat=%0d busy=%0d expected %0d/%0d", i, lat, busy_n, NBYTES, NBYTES);
            end
            checks++;
            if ({sum_out, cout, ovf} !== {ts[i], tco[i], tov[i]}) begin
                errors++;
                $display("FAIL directed%0d_result: sum=%h cout=%b ovf=%b expected %h %b %b",
                         i, sum_out, cout, ovf, ts[i], tco[i], tov[i]);
            end
            checks++;
            if (cin_tr[3:0] !== {3'b000, tc[i] | (ta[i][7:0] == 8'hFF && tb[i][7:0] != 8'h00)} && i == 2) begin
                errors++;
                $display("FAIL directed%0d_add_cin: trace=%b expected 0001", i, cin_tr[3:0]);
            end
            step();
            checks++;
            if (done !== 1'b0 || sum_out !== ts[i]) begin
                errors++;
                $display("FAIL directed%0d_hold: done=%b sum=%h expected 0 %h", i, done, sum_out, ts[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, es;
        logic c, eco, eov;
        logic [7:0] cin_tr;
        int lat, busy_n;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            if (i % 5 == 0) a[W-1] = b[W-1];
            model(a, b, c, es, eco, eov);
            do_op(a, b, c, lat, busy_n, cin_tr);
            checks++;
            if (lat !== NBYTES) begin
                errors++;
                $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, NBYTES);
            end
            checks++;
            if ({sum_out, cout, ovf} !== {es, eco, eov}) begin
                errors++;
                $display("FAIL random%0d_result: a=%h b=%h cin=%b sum=%h cout=%b ovf=%b expected %h %b %b",
                         i, a, b, c, sum_out, cout, ovf, es, eco, eov);
            end
            checks++;
            if (cin_tr[0] !== c) begin
                errors++;
                $display("FAIL random%0d_first_cin: got %b expected %b", i, cin_tr[0], c);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_ignore_start();
        int lat, dones;
        start = 1'b1;
        a_in  = 32'h12345678;
        b_in  = 32'h11111111;
        cin   = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        a_in  = 32'hFFFFFFFF;
        step();
        start = 1'b0;
        lat   = 3;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== NBYTES || sum_out !== 32'h23456789) begin
            errors++;
            $display("FAIL ignore_start_result: lat=%0d sum=%h expected %0d 23456789", lat, sum_out, NBYTES);
        end
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_single_done: extra dones=%0d busy=%b expected 0 0", dones, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, busy_n, dones;
        logic [7:0] cin_tr;
        start = 1'b1;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        cin   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, ovf, add_cin} !== 5'd0 || sum_out !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy/done/cout/ovf/add_cin=%b sum=%h expected 00000 0",
                     {busy, done, cout, ovf, add_cin}, sum_out);
        end
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: activity cycles=%0d expected 0", dones);
        end
        do_op(32'h000000FF, 32'h00000001, 1'b0, lat, busy_n, cin_tr);
        checks++;
        if (lat !== NBYTES || sum_out !== 32'h00000100 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midrun_recover: lat=%0d sum=%h cout=%b expected %0d 00000100 0", lat, sum_out, cout, NBYTES);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, es;
        logic c, eco, eov, exp_done;
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
        model(a, b, c, es, eco, eov);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        for (int k = 0; k < 15; k++) begin
            step();
            exp_done = (k % (NBYTES + 1)) == NBYTES;
            checks++;
            if (done !== exp_done || busy !== !exp_done) begin
                errors++;
                $display("FAIL b2b_cycle%0d: done=%b busy=%b expected %b %b", k, done, busy, exp_done, !exp_done);
            end
            if (exp_done) begin
                checks++;
                if ({sum_out, cout, ovf} !== {es, eco, eov}) begin
                    errors++;
                    $display("FAIL b2b_result%0d: sum=%h cout=%b ovf=%b expected %h %b %b",
                             k, sum_out, cout, ovf, es, eco, eov);
                end
            end
        end
        start = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
